// File: rtl/ahb2_arbiter_rr.sv
// ahb2_arbiter_rr: AHB2 round-robin bus arbiter with burst guard and locked-transfer hold.
// Ports: hclk/hreset (sync active-high), hbusreq/hlock per-master requests, htrans/hburst/
// hready/hresp bus observation, hsplit split-resume pulses (only with AHB2_ARB_SPLIT_EN),
// hgrant registered one-hot grant, hmaster/hmaster_dp address/data-phase owner, hmastlock.
// Optional feature macro: AHB2_ARB_SPLIT_EN enables split masking.
module ahb2_arbiter_rr #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0,
    localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    input  logic [1:0]         hresp,
`ifdef AHB2_ARB_SPLIT_EN
    input  logic [NUM_MST-1:0] hsplit,
`endif
    output logic [NUM_MST-1:0] hgrant,
    output logic [MW-1:0]      hmaster,
    output logic [MW-1:0]      hmaster_dp,
    output logic               hmastlock
);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SPLIT  = 2'b11;

    logic [NUM_MST-1:0] grant_q, grant_d, eligible;
    logic [MW-1:0]      master_q, master_d, dp_q, dp_d, gidx, next_idx, idx;
    logic               mastlock_q, mastlock_d, lock_hold, burst_guard, arb_ok, found;
    logic [4:0]         cnt_q, cnt_d, burst_len;
    int                 j;

`ifdef AHB2_ARB_SPLIT_EN
    logic [NUM_MST-1:0] split_q, split_d;

    always_comb begin
        split_d = split_q & ~hsplit;
        // set wins over a same-cycle resume of the same master
        if (hresp == SPLIT && !hready) split_d[hmaster_dp] = 1'b1;
    end

    always_ff @(posedge hclk) begin
        if (hreset) split_q <= '0;
        else        split_q <= split_d;
    end

    assign eligible = hbusreq & ~split_q;
`else
    assign eligible = hbusreq;
`endif

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MST; i++) if (grant_q[i]) gidx = MW'(i);
    end

    // search starts after the current address-phase owner, owner itself last
    always_comb begin
        next_idx = MW'(DEF_MST);
        found    = 1'b0;
        j        = 0;
        idx      = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            j   = (int'(master_q) + i) % NUM_MST;
            idx = MW'(j);
            if (!found && eligible[idx]) begin
                next_idx = idx;
                found    = 1'b1;
            end
        end
    end

    // hburst[2:1]: 01 = 4-beat, 10 = 8-beat, 11 = 16-beat, 00 = SINGLE/INCR
    assign burst_len = (hburst[2:1] == 2'b01) ? 5'd3 :
                       (hburst[2:1] == 2'b10) ? 5'd7 :
                       (hburst[2:1] == 2'b11) ? 5'd15 : 5'd0;

    // guard keeps the grant until the edge that accepts the final beat
    assign burst_guard = (cnt_q > 5'd1) ||
                         (cnt_q == 5'd1 && htrans != SEQ) ||
                         (cnt_q == 5'd0 && htrans == NONSEQ && hburst[2:1] != 2'b00);
    assign lock_hold   = hlock[gidx] & hbusreq[gidx];
    assign arb_ok      = hready & ~lock_hold & ~burst_guard;

    always_comb begin
        cnt_d = cnt_q;
        // hresp[1] covers RETRY and SPLIT; the first response cycle has hready low
        if (!hready && hresp[1]) cnt_d = 5'd0;
        else if (hready) begin
            if (htrans == NONSEQ)                   cnt_d = burst_len;
            else if (htrans == SEQ && cnt_q != '0)  cnt_d = cnt_q - 5'd1;
            else if (htrans == IDLE)                cnt_d = 5'd0;
        end
    end

    always_comb begin
        grant_d = grant_q;
        if (arb_ok) begin
            grant_d           = '0;
            grant_d[next_idx] = 1'b1;
        end
        master_d   = hready ? gidx : master_q;
        mastlock_d = hready ? hlock[gidx] : mastlock_q;
        dp_d       = hready ? master_q : dp_q;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            grant_q             <= '0;
            grant_q[DEF_MST]    <= 1'b1;
            master_q            <= MW'(DEF_MST);
            dp_q                <= MW'(DEF_MST);
            mastlock_q          <= 1'b0;
            cnt_q               <= '0;
        end else begin
            grant_q    <= grant_d;
            master_q   <= master_d;
            dp_q       <= dp_d;
            mastlock_q <= mastlock_d;
            cnt_q      <= cnt_d;
        end
    end

    assign hgrant     = grant_q;
    assign hmaster    = master_q;
    assign hmaster_dp = dp_q;
    assign hmastlock  = mastlock_q;
endmodule

// File: tb/tb_ahb2_arbiter_rr.sv
// tb_ahb2_arbiter_rr: directed self-checking bench for ahb2_arbiter_rr (NUM_MST=4, DEF_MST=0).
module tb_ahb2_arbiter_rr;
    logic       hclk = 1'b0;
    logic       hreset, hready, hmastlock;
    logic [3:0] hbusreq, hlock, hgrant;
    logic [1:0] htrans, hresp, hmaster, hmaster_dp;
    logic [2:0] hburst;
`ifdef AHB2_ARB_SPLIT_EN
    logic [3:0] hsplit;
`endif
    int passed = 0;
    int total  = 0;

    ahb2_arbiter_rr #(.NUM_MST(4), .DEF_MST(0)) dut (
        .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
`ifdef AHB2_ARB_SPLIT_EN
        .hsplit(hsplit),
`endif
        .hgrant(hgrant), .hmaster(hmaster), .hmaster_dp(hmaster_dp), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        hbusreq = 4'b0000; hlock = 4'b0000; htrans = 2'b00; hburst = 3'b000;
        hready = 1'b1; hresp = 2'b00;
`ifdef AHB2_ARB_SPLIT_EN
        hsplit = 4'b0000;
`endif
    endtask

    task automatic do_reset();
        idle_bus();
        hreset = 1'b1;
        step();
        step();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (hgrant !== 4'b0001) $display("FAIL reset_grant got=%b exp=0001", hgrant); else passed++;
        total++; if (hmaster !== 2'd0) $display("FAIL reset_hmaster got=%0d exp=0", hmaster); else passed++;
        total++; if (hmaster_dp !== 2'd0) $display("FAIL reset_hmaster_dp got=%0d exp=0", hmaster_dp); else passed++;
        total++; if (hmastlock !== 1'b0) $display("FAIL reset_hmastlock got=%b exp=0", hmastlock); else passed++;
        step();
        total++; if (hgrant !== 4'b0001) $display("FAIL reset_idle_grant got=%b exp=0001", hgrant); else passed++;
    endtask

    // grant follows hmaster+1, and hmaster trails hgrant by one edge
    task automatic test_rotation();
        logic [3:0] eg [9] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
        logic [1:0] em [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        logic [1:0] ed [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        do_reset();
        hbusreq = 4'b1111; htrans = 2'b10; hburst = 3'b000;
        for (int k = 0; k < 9; k++) begin
            step();
            total++; if (hgrant !== eg[k]) $display("FAIL rot_grant[%0d] got=%b exp=%b", k, hgrant, eg[k]); else passed++;
            total++; if (hmaster !== em[k]) $display("FAIL rot_hmaster[%0d] got=%0d exp=%0d", k, hmaster, em[k]); else passed++;
            total++; if (hmaster_dp !== ed[k]) $display("FAIL rot_hmaster_dp[%0d] got=%0d exp=%0d", k, hmaster_dp, ed[k]); else passed++;
        end
    endtask

    task automatic test_incr8();
        do_reset();
        hbusreq = 4'b0100;
        step();
        step();
        total++; if (hgrant !== 4'b0100 || hmaster !== 2'd2) $display("FAIL incr8_setup got=%b/%0d exp=0100/2", hgrant, hmaster); else passed++;
        hbusreq = 4'b1100; htrans = 2'b10; hburst = 3'b101;
        step();
        total++; if (hgrant !== 4'b0100) $display("FAIL incr8_nonseq got=%b exp=0100", hgrant); else passed++;
        htrans = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step();
            total++; if (hgrant !== 4'b0100) $display("FAIL incr8_seq[%0d] got=%b exp=0100", k, hgrant); else passed++;
        end
        step();
        total++; if (hgrant !== 4'b1000) $display("FAIL incr8_handover got=%b exp=1000", hgrant); else passed++;
        total++; if (hmaster !== 2'd2) $display("FAIL incr8_hmaster_lag got=%0d exp=2", hmaster); else passed++;
        htrans = 2'b00;
        step();
        total++; if (hmaster !== 2'd3) $display("FAIL incr8_hmaster got=%0d exp=3", hmaster); else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        hbusreq = 4'b0010; hlock = 4'b0010;
        step();
        step();
        hbusreq = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (hgrant !== 4'b0010) $display("FAIL lock_grant[%0d] got=%b exp=0010", k, hgrant); else passed++;
            total++; if (hmastlock !== 1'b1) $display("FAIL lock_mastlock[%0d] got=%b exp=1", k, hmastlock); else passed++;
        end
        hlock = 4'b0000;
        step();
        total++; if (hgrant !== 4'b0100) $display("FAIL lock_release got=%b exp=0100", hgrant); else passed++;
        total++; if (hmastlock !== 1'b0) $display("FAIL lock_mastlock_drop got=%b exp=0", hmastlock); else passed++;
    endtask

    task automatic test_retry();
        do_reset();
        hbusreq = 4'b0010;
        step();
        step();
        hbusreq = 4'b0110; htrans = 2'b10; hburst = 3'b011;
        step();
        htrans = 2'b11;
        step();
        total++; if (hgrant !== 4'b0010) $display("FAIL retry_burst got=%b exp=0010", hgrant); else passed++;
        hready = 1'b0; hresp = 2'b10;
        step();
        total++; if (hgrant !== 4'b0010) $display("FAIL retry_wait got=%b exp=0010", hgrant); else passed++;
        hready = 1'b1; hresp = 2'b00; htrans = 2'b00;
        step();
        total++; if (hgrant !== 4'b0100) $display("FAIL retry_clear got=%b exp=0100", hgrant); else passed++;
    endtask

`ifdef AHB2_ARB_SPLIT_EN
    task automatic test_split();
        do_reset();
        hbusreq = 4'b1000;
        step();
        step();
        step();
        total++; if (hmaster_dp !== 2'd3) $display("FAIL split_setup got=%0d exp=3", hmaster_dp); else passed++;
        hready = 1'b0; hresp = 2'b11;
        step();
        hready = 1'b1; hresp = 2'b00; hbusreq = 4'b1001;
        step();
        total++; if (hgrant !== 4'b0001) $display("FAIL split_masked got=%b exp=0001", hgrant); else passed++;
        step();
        total++; if (hgrant !== 4'b0001) $display("FAIL split_masked2 got=%b exp=0001", hgrant); else passed++;
        hbusreq = 4'b1000;
        step();
        total++; if (hgrant !== 4'b0001) $display("FAIL split_default got=%b exp=0001", hgrant); else passed++;
        hsplit = 4'b1000;
        step();
        hsplit = 4'b0000;
        total++; if (hgrant !== 4'b0001) $display("FAIL split_resume_edge got=%b exp=0001", hgrant); else passed++;
        step();
        total++; if (hgrant !== 4'b1000) $display("FAIL split_regrant got=%b exp=1000", hgrant); else passed++;
    endtask
`endif

    task automatic test_reset_mid_burst();
        do_reset();
        hbusreq = 4'b0010;
        step();
        step();
        hbusreq = 4'b0011; htrans = 2'b10; hburst = 3'b111;
        step();
        htrans = 2'b11;
        step();
        step();
        total++; if (hgrant !== 4'b0010) $display("FAIL rst_burst_hold got=%b exp=0010", hgrant); else passed++;
        hreset = 1'b1;
        step();
        total++; if (hgrant !== 4'b0001) $display("FAIL rst_burst_grant got=%b exp=0001", hgrant); else passed++;
        total++; if (hmaster !== 2'd0) $display("FAIL rst_burst_hmaster got=%0d exp=0", hmaster); else passed++;
        hreset = 1'b0; hbusreq = 4'b0010; htrans = 2'b00;
        step();
        total++; if (hgrant !== 4'b0010) $display("FAIL rst_burst_noguard got=%b exp=0010", hgrant); else passed++;
    endtask

    initial begin
        idle_bus();
        hreset = 1'b1;
        test_reset();
        test_rotation();
        test_incr8();
        test_lock();
        test_retry();
`ifdef AHB2_ARB_SPLIT_EN
        test_split();
`endif
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ahb2_arbiter_rr.md
AHB2_ARBITER_RR -- requirements
Module: ahb2_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NUM_MST, default 4, number of masters, legal range 2..16.
REQ-002 The block SHALL have parameter DEF_MST, default 0, default-master index (0..NUM_MST-1).
REQ-003 The block SHALL derive MW = max(1, clog2(NUM_MST)) as the master-index width.
REQ-004 hclk  input  1  single clock; all state updates on the rising edge.
REQ-005 hreset  input  1  reset; synchronous, active-high.
REQ-006 hbusreq  input  NUM_MST  per-master bus request.
REQ-007 hlock  input  NUM_MST  per-master locked-access request.
REQ-008 htrans  input  2  address-phase transfer type of the current owner.
REQ-009 hburst  input  3  address-phase burst type.
REQ-010 hready  input  1  bus ready.
REQ-011 hresp  input  2  slave response.
REQ-012 hsplit  input  NUM_MST  split-resume pulse per master; present only with AHB2_ARB_SPLIT_EN.
REQ-013 hgrant  output  NUM_MST  registered one-hot grant.
REQ-014 hmaster  output  MW  address-phase owner index.
REQ-015 hmaster_dp  output  MW  data-phase owner index.
REQ-016 hmastlock  output  1  current address phase is locked.

Function
REQ-017 eligible = hbusreq & ~split_mask; split_mask is all-zero when AHB2_ARB_SPLIT_EN is undefined.
REQ-018 next_grant SHALL be the first eligible index searching hmaster+1, hmaster+2, ... modulo NUM_MST, hmaster itself last; if none is eligible, next_grant SHALL be DEF_MST.
REQ-019 hgrant SHALL load one-hot(next_grant) on an edge only when arb_ok = hready & !lock_hold & !burst_guard; otherwise it holds.
REQ-020 lock_hold SHALL be 1 when hlock[index of hgrant] = 1 and hbusreq of that master = 1.
REQ-021 Beat counter cnt (5 bits): on an edge with hready=1 and htrans=NONSEQ, load 3 for INCR4/WRAP4, 7 for INCR8/WRAP8, 15 for INCR16/WRAP16, and 0 for SINGLE/INCR.
REQ-022 cnt SHALL decrement on an edge with hready=1, htrans=SEQ and cnt>0; SHALL clear on hready=1 with htrans=IDLE; SHALL hold on BUSY.
REQ-023 burst_guard SHALL be 1 when cnt>1, or when cnt=1 and htrans is not SEQ, or when cnt=0 and htrans=NONSEQ with a fixed-length hburst; undefined-length INCR is never guarded.
REQ-024 hmaster SHALL load index(hgrant) and hmastlock SHALL load hlock[index(hgrant)] on each edge with hready=1.
REQ-025 hmaster_dp SHALL load hmaster on each edge with hready=1.
REQ-026 On hresp in {RETRY, SPLIT} with hready=0 (first response cycle), cnt SHALL clear to 0.
REQ-027 Handover SHALL occur as follows: hgrant moves at the edge accepting the last burst beat, and hmaster follows at the next hready edge.
REQ-028 hgrant SHALL always be exactly one-hot.

Reset
REQ-029 While hreset=1 at an edge, the block SHALL set: hgrant = one-hot(DEF_MST); hmaster = DEF_MST; hmaster_dp = DEF_MST; hmastlock = 0; cnt = 0; split_mask = 0.
REQ-030 Reset SHALL take priority over every simultaneous event, including assertion mid-burst.

Configuration
REQ-031 The macro AHB2_ARB_SPLIT_EN, when defined, SHALL enable the following SPLIT handling:
- An edge with hresp=SPLIT and hready=0 sets split_mask[hmaster_dp].
- hsplit[m]=1 clears split_mask[m].
- If set and clear hit the same bit in the same cycle, set wins.
- A masked DEF_MST may still receive the default grant.
REQ-032 When AHB2_ARB_SPLIT_EN is undefined, the hsplit port and split_mask SHALL be absent, and SPLIT SHALL be handled identically to RETRY.

Verification
REQ-033 Reset with NUM_MST=4, DEF_MST=0, hbusreq=0 -> hgrant=4'b0001, hmaster=0, hmastlock=0 on the first post-reset cycle.
REQ-034 hbusreq=4'b1111 held, only SINGLE transfers -> grants rotate 1,2,3,0,1 on successive arb_ok edges.
REQ-035 Master 2 issues an INCR8 with hready=1, while master 3 requests -> hgrant stays 4'b0100 for 7 SEQ beats and moves to 4'b1000 at the edge accepting beat 8.
REQ-036 Master 1 holds hlock=1 with hbusreq=1 while masters 0 and 2 request -> hgrant stays 4'b0010 until hlock[1] drops; hmastlock=1 throughout.
REQ-037 With AHB2_ARB_SPLIT_EN defined: SPLIT to master 3 -> master 3 is not granted despite hbusreq[3]=1; hsplit[3] pulse -> master 3 is granted on its next round-robin turn.
REQ-038 hreset asserted at beat 4 of an INCR16 -> cnt=0 and hgrant=4'b0001 next cycle, and no guard remains.
